// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART command sequencer: opcodes, operand
// addresses, FSM state encoding and small decode helpers.
package uart_ctrl_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        ALU_A,
        ALU_B,
        ALU_FUN,
        ALU_WAIT,
        TX_SEND
    } state_t;

    // First state of a frame for a given opcode; IDLE means "not a command".
    function automatic state_t cmd_to_state(input logic [7:0] cmd);
        case (cmd)
            CMD_WR:      return WR_ADDR;
            CMD_RD:      return RD_ADDR;
            CMD_ALU_OP:  return ALU_A;
            CMD_ALU_NOP: return ALU_FUN;
            default:     return IDLE;
        endcase
    endfunction

    // States that are waiting for the next byte of a partially received frame.
    function automatic logic is_mid_frame(input state_t s);
        return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR) ||
               (s == ALU_A)   || (s == ALU_B)   || (s == ALU_FUN);
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of the UART RX/TX, register-file and ALU handshake signals seen by
// the command sequencer. master = sequencer side, slave = peripheral side.
interface uart_cmd_ctrl_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int TX_DATA_WIDTH = 16,
    parameter int FUN_WIDTH     = 4
);
    logic [DATA_WIDTH-1:0]    RX_P_DATA;
    logic                     RX_D_VLD;
    logic [TX_DATA_WIDTH-1:0] TX_P_DATA;
    logic                     TX_D_VLD;
    logic                     TX_Busy;
    logic                     WrEn;
    logic                     RdEn;
    logic [ADDR_WIDTH-1:0]    Address;
    logic [DATA_WIDTH-1:0]    WrData;
    logic [DATA_WIDTH-1:0]    RdData;
    logic                     RdData_Valid;
    logic                     ALU_EN;
    logic [FUN_WIDTH-1:0]     ALU_FUN;
    logic [TX_DATA_WIDTH-1:0] ALU_OUT;
    logic                     OUT_Valid;
    logic                     CLK_GATE_EN;
    logic                     Frame_Drop;

    modport master (
        input  RX_P_DATA, RX_D_VLD, TX_Busy, RdData, RdData_Valid, ALU_OUT, OUT_Valid,
        output TX_P_DATA, TX_D_VLD, WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN,
               CLK_GATE_EN, Frame_Drop
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, TX_Busy, RdData, RdData_Valid, ALU_OUT, OUT_Valid,
        input  TX_P_DATA, TX_D_VLD, WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN,
               CLK_GATE_EN, Frame_Drop
    );

endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: decodes framed commands into regfile/ALU strobes and
// returns results to the UART TX. Define UART_CMD_CTRL_TIMEOUT_EN for a frame timeout.
module uart_cmd_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int TX_DATA_WIDTH = 16,
    parameter int FUN_WIDTH     = 4
`ifdef UART_CMD_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_W     = 16
`endif
) (
    input  logic            CLK,
    input  logic            RST,
    uart_cmd_ctrl_if.master bus
);

    state_t                   state_reg, state_next;
    logic [ADDR_WIDTH-1:0]    addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]    wr_data_reg, wr_data_next;
    logic [FUN_WIDTH-1:0]     fun_reg, fun_next;
    logic [TX_DATA_WIDTH-1:0] tx_data_reg, tx_data_next;
    logic                     wr_en_reg, wr_en_next;
    logic                     rd_en_reg, rd_en_next;
    logic                     alu_en_reg, alu_en_next;
    logic                     gate_reg, gate_next;
    logic                     drop_reg, drop_next;

    logic                     rx_vld;
    logic [DATA_WIDTH-1:0]    rx_byte;
    logic                     timeout_hit;
    state_t                   cmd_state;

    assign rx_vld    = bus.RX_D_VLD;
    assign rx_byte   = bus.RX_P_DATA;
    assign cmd_state = cmd_to_state(rx_byte[7:0]);

`ifdef UART_CMD_CTRL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_reg;
    logic                 mid_frame;

    assign mid_frame = is_mid_frame(state_reg);

    // Counts idle cycles between bytes of a frame; any byte restarts it.
    always_ff @(posedge CLK) begin
        if (RST || rx_vld || !mid_frame) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TIMEOUT_W'(1);
        end
    end

    assign timeout_hit = mid_frame && !rx_vld && (tmo_cnt_reg == '1);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        wr_data_next = wr_data_reg;
        fun_next     = fun_reg;
        tx_data_next = tx_data_reg;
        wr_en_next   = 1'b0;
        rd_en_next   = 1'b0;
        alu_en_next  = 1'b0;
        drop_next    = 1'b0;

        if (timeout_hit) begin
            state_next = IDLE;
            drop_next  = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rx_vld) begin
                        state_next = cmd_state;
                        drop_next  = (cmd_state == IDLE);
                    end
                end
                WR_ADDR: begin
                    if (rx_vld) begin
                        addr_next  = rx_byte[ADDR_WIDTH-1:0];
                        state_next = WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (rx_vld) begin
                        wr_data_next = rx_byte;
                        wr_en_next   = 1'b1;
                        state_next   = IDLE;
                    end
                end
                RD_ADDR: begin
                    if (rx_vld) begin
                        addr_next  = rx_byte[ADDR_WIDTH-1:0];
                        rd_en_next = 1'b1;
                        state_next = RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    drop_next = rx_vld;
                    if (bus.RdData_Valid) begin
                        tx_data_next = TX_DATA_WIDTH'(bus.RdData);
                        state_next   = TX_SEND;
                    end
                end
                ALU_A: begin
                    if (rx_vld) begin
                        addr_next    = ADDR_WIDTH'(OPA_ADDR);
                        wr_data_next = rx_byte;
                        wr_en_next   = 1'b1;
                        state_next   = ALU_B;
                    end
                end
                ALU_B: begin
                    if (rx_vld) begin
                        addr_next    = ADDR_WIDTH'(OPB_ADDR);
                        wr_data_next = rx_byte;
                        wr_en_next   = 1'b1;
                        state_next   = ALU_FUN;
                    end
                end
                ALU_FUN: begin
                    if (rx_vld) begin
                        fun_next    = rx_byte[FUN_WIDTH-1:0];
                        alu_en_next = 1'b1;
                        state_next  = ALU_WAIT;
                    end
                end
                ALU_WAIT: begin
                    drop_next = rx_vld;
                    if (bus.OUT_Valid) begin
                        tx_data_next = bus.ALU_OUT;
                        state_next   = TX_SEND;
                    end
                end
                TX_SEND: begin
                    drop_next = rx_vld;
                    if (!bus.TX_Busy) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // Registered from the next state so the ALU clock is already running
        // in the cycle ALU_EN is presented.
        gate_next = (state_next == ALU_FUN) || (state_next == ALU_WAIT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            wr_data_reg <= '0;
            fun_reg     <= '0;
            tx_data_reg <= '0;
            wr_en_reg   <= 1'b0;
            rd_en_reg   <= 1'b0;
            alu_en_reg  <= 1'b0;
            gate_reg    <= 1'b0;
            drop_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            wr_data_reg <= wr_data_next;
            fun_reg     <= fun_next;
            tx_data_reg <= tx_data_next;
            wr_en_reg   <= wr_en_next;
            rd_en_reg   <= rd_en_next;
            alu_en_reg  <= alu_en_next;
            gate_reg    <= gate_next;
            drop_reg    <= drop_next;
        end
    end

    // Strobes are masked by RST so a reset cycle can never commit an access.
    assign bus.WrEn        = wr_en_reg  && !RST;
    assign bus.RdEn        = rd_en_reg  && !RST;
    assign bus.ALU_EN      = alu_en_reg && !RST;
    assign bus.TX_D_VLD    = (state_reg == TX_SEND) && !bus.TX_Busy && !RST;
    assign bus.TX_P_DATA   = tx_data_reg;
    assign bus.Address     = addr_reg;
    assign bus.WrData      = wr_data_reg;
    assign bus.ALU_FUN     = fun_reg;
    assign bus.CLK_GATE_EN = gate_reg;
    assign bus.Frame_Drop  = drop_reg;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: table of command frames with expected
// strobes/results fed through per-kind scoreboard queues, plus corner-case sequences.
module tb_uart_cmd_ctrl;

    logic CLK;
    logic RST;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          nbytes;
        logic [7:0]  b0, b1, b2, b3;
        int          resp;       // 0 none, 1 regfile read data, 2 ALU result
        logic [15:0] resp_data;
        int          busy;       // TX_Busy cycles after the result pulse
        int          n_wr;
        logic [11:0] wr0, wr1;   // {addr, data}
        bit          has_rd;
        logic [3:0]  rd_a;
        bit          has_alu;
        logic [3:0]  fun;
        bit          has_tx;
        logic [15:0] tx_d;
        int          n_drop;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    logic [11:0] q_wr  [$];
    logic [3:0]  q_rd  [$];
    logic [3:0]  q_alu [$];
    logic [15:0] q_tx  [$];
    int          exp_drop;
    int          n_vec;
    int          n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [11:0] ew;
        logic [3:0]  e4;
        logic [15:0] et;
        if (bus.WrEn === 1'b1) begin
            chk("wr_expected", 32'(q_wr.size() > 0), 32'd1);
            if (q_wr.size() > 0) begin
                ew = q_wr.pop_front();
                chk("wr_addr_data", 32'({bus.Address, bus.WrData}), 32'(ew));
            end
        end
        if (bus.RdEn === 1'b1) begin
            chk("rd_expected", 32'(q_rd.size() > 0), 32'd1);
            if (q_rd.size() > 0) begin
                e4 = q_rd.pop_front();
                chk("rd_addr", 32'(bus.Address), 32'(e4));
            end
        end
        if (bus.ALU_EN === 1'b1) begin
            chk("alu_expected", 32'(q_alu.size() > 0), 32'd1);
            chk("gate_at_alu_en", 32'(bus.CLK_GATE_EN), 32'd1);
            if (q_alu.size() > 0) begin
                e4 = q_alu.pop_front();
                chk("alu_fun", 32'(bus.ALU_FUN), 32'(e4));
            end
        end
        if (bus.TX_D_VLD === 1'b1) begin
            chk("tx_expected", 32'(q_tx.size() > 0), 32'd1);
            chk("tx_while_busy", 32'(bus.TX_Busy), 32'd0);
            if (q_tx.size() > 0) begin
                et = q_tx.pop_front();
                chk("tx_data", 32'(bus.TX_P_DATA), 32'(et));
            end
        end
        if (bus.Frame_Drop === 1'b1) begin
            chk("drop_expected", 32'(exp_drop > 0), 32'd1);
            if (exp_drop > 0) exp_drop--;
        end
    endtask

    // Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(negedge CLK);
        monitor();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        tick();
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic drain_and_check(input string name);
        repeat (3) tick();
        chk(name, 32'(q_wr.size() + q_rd.size() + q_alu.size() + q_tx.size() + exp_drop), 32'd0);
        chk("gate_idle", 32'(bus.CLK_GATE_EN), 32'd0);
        q_wr.delete();
        q_rd.delete();
        q_alu.delete();
        q_tx.delete();
        exp_drop = 0;
    endtask

    task automatic apply_vec(input int i);
        vec_t v;
        int   n;
        v = vecs[i];
        if (v.n_wr >= 1) q_wr.push_back(v.wr0);
        if (v.n_wr >= 2) q_wr.push_back(v.wr1);
        if (v.has_rd)    q_rd.push_back(v.rd_a);
        if (v.has_alu)   q_alu.push_back(v.fun);
        if (v.has_tx)    q_tx.push_back(v.tx_d);
        exp_drop += v.n_drop;

        send_byte(v.b0);
        if (v.nbytes > 1) send_byte(v.b1);
        if (v.nbytes > 2) send_byte(v.b2);
        if (v.nbytes > 3) send_byte(v.b3);

        if (v.resp != 0) begin
            n = 0;
            while (!((v.resp == 1) ? bus.RdEn : bus.ALU_EN) && n < 10) begin
                tick();
                n++;
            end
            chk("strobe_latency", 32'(n), 32'd0);
            repeat (3) tick();
            if (v.resp == 2) chk("gate_in_wait", 32'(bus.CLK_GATE_EN), 32'd1);
            bus.TX_Busy = (v.busy > 0);
            if (v.resp == 1) begin
                bus.RdData       = v.resp_data[7:0];
                bus.RdData_Valid = 1'b1;
            end else begin
                bus.ALU_OUT   = v.resp_data;
                bus.OUT_Valid = 1'b1;
            end
            tick();
            bus.RdData_Valid = 1'b0;
            bus.OUT_Valid    = 1'b0;
            repeat (v.busy) tick();
            bus.TX_Busy = 1'b0;
            #1;
            chk("tx_first_idle_cycle", 32'(bus.TX_D_VLD), 32'd1);
        end
        drain_and_check("vector_pending");
        $display("vec %0d: %0d byte(s) from 0x%h, resp %0d, busy %0d applied", i, v.nbytes, v.b0, v.resp, v.busy);
    endtask

    task automatic check_outputs_zero();
        chk("rst_wren",   32'(bus.WrEn),        32'd0);
        chk("rst_rden",   32'(bus.RdEn),        32'd0);
        chk("rst_aluen",  32'(bus.ALU_EN),      32'd0);
        chk("rst_txvld",  32'(bus.TX_D_VLD),    32'd0);
        chk("rst_txdata", 32'(bus.TX_P_DATA),   32'd0);
        chk("rst_addr",   32'(bus.Address),     32'd0);
        chk("rst_wrdata", 32'(bus.WrData),      32'd0);
        chk("rst_fun",    32'(bus.ALU_FUN),     32'd0);
        chk("rst_gate",   32'(bus.CLK_GATE_EN), 32'd0);
        chk("rst_drop",   32'(bus.Frame_Drop),  32'd0);
    endtask

    initial begin
        int n;
        n_vec    = 0;
        n_err    = 0;
        exp_drop = 0;

        vecs[0] = '{3, 8'hAA, 8'h05, 8'h3C, 8'h00, 0, 16'h0000, 0,  1, 12'h53C, 12'h000, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 16'h0000, 0};
        vecs[1] = '{2, 8'hBB, 8'h05, 8'h00, 8'h00, 1, 16'h003C, 0,  0, 12'h000, 12'h000, 1'b1, 4'h5, 1'b0, 4'h0, 1'b1, 16'h003C, 0};
        vecs[2] = '{4, 8'hCC, 8'h0A, 8'h14, 8'h00, 2, 16'h001E, 0,  2, 12'h00A, 12'h114, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 16'h001E, 0};
        vecs[3] = '{2, 8'hDD, 8'h02, 8'h00, 8'h00, 2, 16'h1234, 20, 0, 12'h000, 12'h000, 1'b0, 4'h0, 1'b1, 4'h2, 1'b1, 16'h1234, 0};
        vecs[4] = '{1, 8'h7F, 8'h00, 8'h00, 8'h00, 0, 16'h0000, 0,  0, 12'h000, 12'h000, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 16'h0000, 1};
        vecs[5] = '{3, 8'hAA, 8'h0F, 8'hFF, 8'h00, 0, 16'h0000, 0,  1, 12'hFFF, 12'h000, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 16'h0000, 0};
        vecs[6] = '{2, 8'hBB, 8'h1A, 8'h00, 8'h00, 1, 16'h00A5, 0,  0, 12'h000, 12'h000, 1'b1, 4'hA, 1'b0, 4'h0, 1'b1, 16'h00A5, 0};
        vecs[7] = '{4, 8'hCC, 8'hFF, 8'h00, 8'h3B, 2, 16'hBEEF, 3,  2, 12'h0FF, 12'h100, 1'b0, 4'h0, 1'b1, 4'hB, 1'b1, 16'hBEEF, 0};
        vecs[8] = '{2, 8'hDD, 8'h1F, 8'h00, 8'h00, 2, 16'h0001, 0,  0, 12'h000, 12'h000, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 16'h0001, 0};
        vecs[9] = '{1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0000, 0,  0, 12'h000, 12'h000, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 16'h0000, 1};

        RST              = 1'b1;
        bus.RX_P_DATA    = '0;
        bus.RX_D_VLD     = 1'b0;
        bus.TX_Busy      = 1'b0;
        bus.RdData       = '0;
        bus.RdData_Valid = 1'b0;
        bus.ALU_OUT      = '0;
        bus.OUT_Valid    = 1'b0;
        repeat (3) tick();
        RST = 1'b0;
        check_outputs_zero();
        $display("reset: outputs checked after power-on reset");

        for (int i = 0; i < NV; i++) begin
            apply_vec(i);
        end

        // Byte arriving while a read is outstanding is dropped; the read still completes.
        q_rd.push_back(4'h3);
        q_tx.push_back(16'h0077);
        exp_drop += 1;
        send_byte(8'hBB);
        send_byte(8'h03);
        tick();
        send_byte(8'h55);
        tick();
        bus.RdData       = 8'h77;
        bus.RdData_Valid = 1'b1;
        tick();
        bus.RdData_Valid = 1'b0;
        drain_and_check("rd_wait_drop_pending");
        $display("seq: byte during RD_WAIT dropped, read 0x03 completed");

        // Result and stray byte in the same cycle: result taken, byte dropped.
        q_rd.push_back(4'h4);
        q_tx.push_back(16'h0042);
        exp_drop += 1;
        send_byte(8'hBB);
        send_byte(8'h04);
        tick();
        bus.RX_P_DATA    = 8'h99;
        bus.RX_D_VLD     = 1'b1;
        bus.RdData       = 8'h42;
        bus.RdData_Valid = 1'b1;
        tick();
        bus.RX_D_VLD     = 1'b0;
        bus.RdData_Valid = 1'b0;
        drain_and_check("simultaneous_pending");
        $display("seq: simultaneous RdData_Valid and RX byte");

        // Reset in the middle of a write frame, then a fresh write.
        send_byte(8'hAA);
        send_byte(8'h05);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_outputs_zero();
        q_wr.push_back(12'h611);
        send_byte(8'hAA);
        send_byte(8'h06);
        send_byte(8'h11);
        drain_and_check("post_reset_pending");
        $display("seq: reset mid-frame, then write addr 6");

        // Reset coinciding with the write strobe cycle must mask the strobe.
        send_byte(8'hAA);
        send_byte(8'h07);
        send_byte(8'h22);
        RST = 1'b1;
        #1;
        chk("wren_masked_by_rst", 32'(bus.WrEn), 32'd0);
        tick();
        RST = 1'b0;
        drain_and_check("rst_strobe_pending");
        $display("seq: reset during write strobe cycle");

`ifdef UART_CMD_CTRL_TIMEOUT_EN
        exp_drop += 1;
        send_byte(8'hAA);
        n = 0;
        while (!bus.Frame_Drop && n < 70000) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 32'(n >= 65534 && n <= 65537), 32'd1);
        q_wr.push_back(12'h622);
        send_byte(8'hAA);
        send_byte(8'h06);
        send_byte(8'h22);
        drain_and_check("timeout_pending");
        $display("seq: frame timeout after %0d idle cycles", n);
`else
        n = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
